// File: rtl/seg7_scan_driver_if.sv
// Display bus between the calculator FSM (master) and the seven-segment scan driver (slave).
// Value and flags flow toward the driver; anode, segment and decimal-point pins flow out of it.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  flags;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        dp;

    modport master (output value, flags, input anodes, segments, dp);
    modport slave  (input value, flags, output anodes, segments, dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit muxed 7-seg driver: per-frame snapshot of value/flags. Optional SEG7_LZB_EN blanks leading zeros.
// Latency: a frame-start sample reaches digit 0 two cycles later. No backpressure: the scan is free-running.
module seg7_scan_driver #(
    parameter int C_REFRESH_DIV = 100000
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);

    localparam int            CW      = $clog2(C_REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(C_REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q,      cnt_d;
    logic [2:0]    idx_q,      idx_d;
    logic [19:0]   snap_q,     snap_d;
    logic [2:0]    idx_s2_q,   idx_s2_d;
    logic          vld_s2_q,   vld_s2_d;
    logic [7:0]    anodes_q,   anodes_d;
    logic [6:0]    segments_q, segments_d;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Digits 4..7 show one flag bit each; digits 0..3 show the hex nibbles of the snapshot value.
    function automatic logic [6:0] digit_glyph(input logic [19:0] s, input logic [2:0] k);
        logic [15:0] val;
        logic [3:0]  fl;
        logic [15:0] sh;
        logic [6:0]  g;
        val = s[19:4];
        fl  = s[3:0];
        sh  = val >> {k[1:0], 2'b00};
        if (k[2]) begin
            g = fl[k[1:0]] ? 7'h79 : 7'h40;
        end else begin
            g = hex_glyph(sh[3:0]);
`ifdef SEG7_LZB_EN
            if (k[1:0] != 2'd0 && sh == 16'h0000) begin
                g = 7'h7F;
            end
`endif
        end
        return g;
    endfunction

    always_comb begin
        cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        idx_d      = (cnt_q == CNT_MAX) ? idx_q + 3'd1 : idx_q;
        snap_d     = (cnt_q == '0 && idx_q == 3'd0) ? {bus.value, bus.flags} : snap_q;
        idx_s2_d   = idx_q;
        vld_s2_d   = 1'b1;
        anodes_d   = vld_s2_q ? ~(8'h01 << idx_s2_q) : 8'hFF;
        segments_d = vld_s2_q ? digit_glyph(snap_q, idx_s2_q) : 7'h7F;
    end

    // Pipeline valid keeps the pins blank until snap and idx_s2 hold post-reset data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            snap_q     <= 20'h0;
            idx_s2_q   <= 3'd0;
            vld_s2_q   <= 1'b0;
            anodes_q   <= 8'hFF;
            segments_q <= 7'h7F;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            idx_s2_q   <= idx_s2_d;
            vld_s2_q   <= vld_s2_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.segments = segments_q;
    assign bus.dp       = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: every cycle is compared against a frame/dwell model derived from elapsed cycles.
module tb_seg7_scan_driver;

    localparam int D     = 4;
    localparam int FRAME = 8 * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.C_REFRESH_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;
    bit          prev_rst;
    logic [19:0] snaps [int];
    logic [15:0] stim_value;
    logic [3:0]  stim_flags;
    bit          stim_rst;
    bit          rand_mode;
    logic [7:0]  last_an;
    int          run_len;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d since reset)", tag, got, exp, n);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [19:0] s, input int k);
        logic [15:0] v;
        v = s[19:4];
        if (k >= 4) return s[k-4] ? 7'h79 : 7'h40;
`ifdef SEG7_LZB_EN
        if (k > 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
`endif
        return glyph(int'((v >> (4 * k)) & 16'hF));
    endfunction

    task automatic check_outputs();
        logic [7:0] ea;
        logic [6:0] es;
        int m, k, f;
        if (n < 2) begin
            ea = 8'hFF;
            es = 7'h7F;
        end else begin
            m  = n - 2;
            k  = (m / D) % 8;
            f  = m / FRAME;
            ea = ~(8'h01 << k);
            es = exp_seg(snaps[f], k);
        end
        check_eq("anodes", bus.anodes, ea);
        check_eq("segments", bus.segments, es);
        check_eq("dp", bus.dp, 1);
        if (bus.anodes != 8'hFF)
            check_eq("onehot_low", $countones(~bus.anodes), 1);
        if (bus.anodes == last_an) begin
            run_len++;
        end else begin
            if (last_an != 8'hFF && bus.anodes != 8'hFF)
                check_eq("dwell", run_len, D);
            last_an = bus.anodes;
            run_len = 1;
        end
    endtask

    // Advance one cycle, check what the DUT shows in it, then drive this cycle's inputs.
    task automatic cycle_step();
        @(posedge clk);
        #1;
        if (prev_rst) begin
            n = 0;
            snaps.delete();
        end else begin
            n++;
        end
        check_outputs();
        if (rand_mode) begin
            stim_value = 16'($urandom);
            stim_flags = 4'($urandom);
        end
        bus.value = stim_value;
        bus.flags = stim_flags;
        rst       = stim_rst;
        if (!stim_rst && (n % FRAME) == 0)
            snaps[n / FRAME] = {stim_value, stim_flags};
        prev_rst = stim_rst;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle_step();
    endtask

    task automatic align_to(input int phase);
        for (int i = 0; i < FRAME; i++) begin
            cycle_step();
            if ((n % FRAME) == phase) break;
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.value  = '0;
        bus.flags  = '0;
        stim_value = '0;
        stim_flags = '0;
        stim_rst   = 1'b1;
        prev_rst   = 1'b1;
        rand_mode  = 1'b0;
        n          = 0;
        last_an    = 8'hFF;
        run_len    = 0;

        run(3);

        stim_rst   = 1'b0;
        stim_value = 16'h1234;
        stim_flags = 4'b0101;
        run(2 * FRAME + 4);

        stim_value = 16'hABCD;
        run(FRAME);
        stim_value = 16'hEF09;
        run(2 * FRAME);

        stim_value = 16'h1111;
        align_to(0);
        run(2 + 2 * D);
        stim_value = 16'h2222;
        run(2 * FRAME);

        align_to(2 + 5 * D + 1);
        stim_rst   = 1'b1;
        stim_value = 16'h5A5A;
        cycle_step();
        stim_rst   = 1'b0;
        stim_value = 16'hC3C3;
        stim_flags = 4'b1010;
        run(2 * FRAME);

        rand_mode = 1'b1;
        run(10 * FRAME);
        rand_mode = 1'b0;

        stim_value = 16'h0000;
        stim_flags = 4'b0000;
        align_to(0);
        run(FRAME + 2);
        stim_value = 16'h0100;
        align_to(0);
        run(FRAME + 2);
        stim_value = 16'h0040;
        stim_flags = 4'b1111;
        align_to(0);
        run(FRAME + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
